mem_read_burst_request_generator: RTL and testbench
===================================================

# mem_read_burst_request_generator

Turns a stream of pixel-index fetch requests into AXI4 read-address bursts covering whole cache lines. Consecutive fetches hitting the same line are merged into one request. Pending line requests are queued in a FIFO, and the number of bursts in flight is capped. It sits between the fragment/texture fetch stage and the memory AXI read-address channel, and observes the read-data channel only to count completed bursts.

## Interface
- STREAM_WIDTH, 32: AXI data width in bits (power of two, ≥ PIXEL_WIDTH)
- ADDR_WIDTH, 32: address width in bits
- ID_WIDTH, 8: AXI ID width
- PIXEL_WIDTH, 16: pixel size in bits (8, 16 or 32)
- BURST_BEATS, 4: beats per line burst (power of two, 1..256)
- REQ_FIFO_DEPTH, 4: queued line requests (power of two, ≥ 2)
- MAX_OUTSTANDING, 4: bursts issued but not completed (1..255)

Ports:
- aclk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- confAddr  in  ADDR_WIDTH  byte base address; sampled when a request is popped
- s_fetch_axis_tvalid  in  1  fetch valid
- s_fetch_axis_tready  out  1  fetch ready
- s_fetch_axis_tlast  in  1  last fetch of a primitive/line
- s_fetch_axis_tdest  in  ADDR_WIDTH  pixel index (not a byte address)
- m_mem_axi_arid  out  ID_WIDTH  request ID
- m_mem_axi_araddr  out  ADDR_WIDTH  byte address
- m_mem_axi_arlen  out  8  BURST_BEATS-1, constant
- m_mem_axi_arsize  out  3  log2(STREAM_WIDTH/8), constant
- m_mem_axi_arburst  out  2  1 (INCR), constant
- m_mem_axi_arlock / arcache / arprot  out  1/4/3  0, constant
- m_mem_axi_arvalid  out  1  request valid
- m_mem_axi_arready  in  1  slave ready
- m_mem_axi_rvalid, m_mem_axi_rready, m_mem_axi_rlast  in  1 each  monitored only; used to retire bursts

## Operation
- LINE_PIX = BURST_BEATS*STREAM_WIDTH/PIXEL_WIDTH.
- line tag = tdest >> log2(LINE_PIX).
- araddr = confAddr + (tag << log2(BURST_BEATS*STREAM_WIDTH/8)), truncated to ADDR_WIDTH.
- Fetch acceptance:
  - A beat is accepted when tvalid && tready.
  - tready = !fifo_full (combinational from the FIFO count).
  - With a full FIFO, beats stall even when they would be filtered.
- Tag filter:
  - The register lastTag plus a valid bit is cleared by reset.
  - An accepted beat pushes its tag into the FIFO unless (valid && tag == lastTag).
  - After the check: if tlast, the valid bit is cleared; otherwise lastTag and the valid bit are loaded with the beat's tag.
- Issue state machine:
  - IDLE: arvalid=0. If FIFO is non-empty and outstanding < MAX_OUTSTANDING, pop the head, load araddr, assert arvalid, increment outstanding, go to WAIT.
  - WAIT: hold araddr/arid/arvalid stable until arready. On handshake: arid += 1 (wraps modulo 2^ID_WIDTH), arvalid=0, go to IDLE.
- Outstanding counter:
  - Decrements on rvalid && rready && rlast.
  - If an increment and a decrement land in the same cycle, the count is unchanged.
  - It saturates at 0, so responses still arriving after a reset are ignored.
- FIFO: a simultaneous push and pop with the FIFO full is not possible, because tready=0. When the FIFO is empty, a pushed entry is not popped in the same cycle.

## Timing
- Reset values:
  - arvalid=0, arid=0, araddr=0.
  - arlen, arsize, arburst, arlock, arcache, arprot at their constants.
  - tready=1, FIFO empty, outstanding=0, filter invalid, FSM in IDLE.
- Reset mid-operation: everything is cleared immediately, a pending arvalid is dropped, and queued requests are lost.
- Latency: a beat accepted at edge N (FIFO empty, IDLE, below the limit) makes arvalid high after edge N+1.
- Throughput: at most one AR request every 2 cycles (IDLE→WAIT→IDLE).
- FIFO occupancy is updated at the edge. tready falls in the cycle after the push that fills the FIFO.

## Configuration
- MRGEN_TAG_FILTER_EN:
  - Defined: the tag filter operates as described.
  - Undefined: the filter logic and lastTag are not compiled. Every accepted beat pushes a request, whatever its tag or tlast (useful for memory-bandwidth stress testing).

## Test plan
- Defaults (PIXEL_WIDTH 16, so LINE_PIX=8), confAddr=0x1000, tdest 0..7 with tlast on 7, arready=1 → exactly one request, araddr=0x1000, arlen=3, arsize=2, arid=0.
- tdest 7,8,8,15 with no tlast → two requests, araddr 0x1000 then 0x1010, arid 0 then 1.
- tdest 3 (tlast=1), then tdest 3 → two identical requests at 0x1000. With MRGEN_TAG_FILTER_EN undefined, tdest 3,3,3 → three requests.
- arready=0, five beats with distinct tags → one held in WAIT, tready low after the FIFO holds 4. Raise arready → all 5 issued in order, araddr stable while waiting.
- MAX_OUTSTANDING=2, arready=1, no rlast, 4 distinct tags → exactly 2 requests issue. Each rvalid&rready&rlast pulse releases one more.
- Assert reset while arvalid=1 with 3 FIFO entries → all outputs at their reset values immediately, no further requests, and a later rlast pulse leaves outstanding at 0.

Source files
------------

// File: rtl/mem_read_burst_request_generator.sv
// Converts pixel-index fetches into whole-line AXI4 read-address bursts with a request FIFO and
// an outstanding-burst cap. Optional same-line merging is compiled in with MRGEN_TAG_FILTER_EN.
`timescale 1ns/1ps
module mem_read_burst_request_generator #(
  parameter int unsigned STREAM_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned ID_WIDTH        = 8,
  parameter int unsigned PIXEL_WIDTH     = 16,
  parameter int unsigned BURST_BEATS     = 4,
  parameter int unsigned REQ_FIFO_DEPTH  = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] confAddr,
  input  logic                  s_fetch_axis_tvalid,
  output logic                  s_fetch_axis_tready,
  input  logic                  s_fetch_axis_tlast,
  input  logic [ADDR_WIDTH-1:0] s_fetch_axis_tdest,
  output logic [ID_WIDTH-1:0]   m_mem_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_mem_axi_araddr,
  output logic [7:0]            m_mem_axi_arlen,
  output logic [2:0]            m_mem_axi_arsize,
  output logic [1:0]            m_mem_axi_arburst,
  output logic                  m_mem_axi_arlock,
  output logic [3:0]            m_mem_axi_arcache,
  output logic [2:0]            m_mem_axi_arprot,
  output logic                  m_mem_axi_arvalid,
  input  logic                  m_mem_axi_arready,
  input  logic                  m_mem_axi_rvalid,
  input  logic                  m_mem_axi_rready,
  input  logic                  m_mem_axi_rlast
);

  localparam int unsigned LinePix   = BURST_BEATS * STREAM_WIDTH / PIXEL_WIDTH;
  localparam int unsigned TagShift  = $clog2(LinePix);
  localparam int unsigned LineShift = $clog2(BURST_BEATS * STREAM_WIDTH / 8);
  localparam int unsigned PtrW      = $clog2(REQ_FIFO_DEPTH);
  localparam int unsigned CntW      = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [ID_WIDTH-1:0]   arid_q, arid_d;
  logic [7:0]            out_q, out_d;

  logic [ADDR_WIDTH-1:0] fifo_mem [REQ_FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;

  logic [ADDR_WIDTH-1:0] tag;
  logic                  fifo_full, fifo_empty;
  logic                  accept, push, pop, r_done;

  assign tag        = s_fetch_axis_tdest >> TagShift;
  assign fifo_full  = (count_q == CntW'(REQ_FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign accept     = s_fetch_axis_tvalid && s_fetch_axis_tready;
  assign pop        = (state_q == StIdle) && !fifo_empty && (out_q < 8'(MAX_OUTSTANDING));
  assign r_done     = m_mem_axi_rvalid && m_mem_axi_rready && m_mem_axi_rlast;

  assign s_fetch_axis_tready = !fifo_full;

`ifdef MRGEN_TAG_FILTER_EN
  logic [ADDR_WIDTH-1:0] last_tag_q;
  logic                  tag_vld_q;
  logic                  hit;

  assign hit  = tag_vld_q && (tag == last_tag_q);
  assign push = accept && !hit;

  // tlast ends a run, so the next beat always starts a new request.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      last_tag_q <= '0;
      tag_vld_q  <= 1'b0;
    end else if (accept) begin
      if (s_fetch_axis_tlast) begin
        tag_vld_q <= 1'b0;
      end else begin
        last_tag_q <= tag;
        tag_vld_q  <= 1'b1;
      end
    end
  end
`else
  logic unused_tlast;
  assign unused_tlast = s_fetch_axis_tlast;
  assign push         = accept;
`endif

  always_ff @(posedge aclk) begin
    if (push) fifo_mem[wr_ptr_q] <= tag;
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arid_d   = arid_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          araddr_d = confAddr + (fifo_mem[rd_ptr_q] << LineShift);
          state_d  = StWait;
        end
      end
      StWait: begin
        if (m_mem_axi_arready) begin
          arid_d  = arid_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Completions with nothing outstanding (e.g. stragglers after reset) are dropped.
  always_comb begin
    out_d = out_q;
    if (pop && !r_done) begin
      out_d = out_q + 1'b1;
    end else if (!pop && r_done && (out_q != '0)) begin
      out_d = out_q - 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      araddr_q <= '0;
      arid_q   <= '0;
      out_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      arid_q   <= arid_d;
      out_q    <= out_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign m_mem_axi_arid    = arid_q;
  assign m_mem_axi_araddr  = araddr_q;
  assign m_mem_axi_arvalid = (state_q == StWait);
  assign m_mem_axi_arlen   = 8'(BURST_BEATS - 1);
  assign m_mem_axi_arsize  = 3'($clog2(STREAM_WIDTH / 8));
  assign m_mem_axi_arburst = 2'b01;
  assign m_mem_axi_arlock  = 1'b0;
  assign m_mem_axi_arcache = 4'b0000;
  assign m_mem_axi_arprot  = 3'b000;

endmodule

// File: tb/tb_mem_read_burst_request_generator.sv
// Directed bench for mem_read_burst_request_generator (defaults, MAX_OUTSTANDING=2); expected
// request counts follow the MRGEN_TAG_FILTER_EN setting.
`timescale 1ns/1ps
module tb_mem_read_burst_request_generator;

  logic        aclk = 1'b0;
  logic        reset;
  logic [31:0] confAddr;
  logic        tvalid, tready, tlast;
  logic [31:0] tdest;
  logic [7:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic        rvalid, rready, rlast;

  int errors = 0;
  int checks = 0;
  logic [31:0] addr_q[$];
  logic [7:0]  id_q[$];

  typedef struct {
    logic [31:0] conf;
    logic [31:0] dest;
    logic [31:0] addr;
  } vec_t;
  vec_t vecs[9];

  always #5 aclk = ~aclk;

  mem_read_burst_request_generator #(.MAX_OUTSTANDING(2)) dut (
    .aclk                (aclk),
    .reset               (reset),
    .confAddr            (confAddr),
    .s_fetch_axis_tvalid (tvalid),
    .s_fetch_axis_tready (tready),
    .s_fetch_axis_tlast  (tlast),
    .s_fetch_axis_tdest  (tdest),
    .m_mem_axi_arid      (arid),
    .m_mem_axi_araddr    (araddr),
    .m_mem_axi_arlen     (arlen),
    .m_mem_axi_arsize    (arsize),
    .m_mem_axi_arburst   (arburst),
    .m_mem_axi_arlock    (arlock),
    .m_mem_axi_arcache   (arcache),
    .m_mem_axi_arprot    (arprot),
    .m_mem_axi_arvalid   (arvalid),
    .m_mem_axi_arready   (arready),
    .m_mem_axi_rvalid    (rvalid),
    .m_mem_axi_rready    (rready),
    .m_mem_axi_rlast     (rlast)
  );

  // Inputs only change just after posedge, so a negedge view predicts the coming handshake.
  always @(negedge aclk) begin
    if (!reset && arvalid && arready) begin
      addr_q.push_back(araddr);
      id_q.push_back(arid);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    tvalid = 1'b1;
    tdest  = d;
    tlast  = l;
    @(negedge aclk);
    while (!tready && n < 100) begin
      n++;
      @(negedge aclk);
    end
    if (!tready) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: got tready=0, expected 1 within 100 cycles");
    end
    @(posedge aclk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic set_r(input logic v);
    rvalid = v;
    rready = v;
    rlast  = v;
  endtask

  task automatic pulse_r();
    set_r(1'b1);
    tick();
    set_r(1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    addr_q.delete();
    id_q.delete();
    reset = 1'b0;
  endtask

  task automatic check_req(input string name, input int idx, input logic [31:0] a,
                           input logic [7:0] id);
    check({name, "_addr"}, addr_q[idx], a);
    check({name, "_id"}, id_q[idx], id);
  endtask

  initial begin
    vecs[0] = '{32'h0000_1000, 32'd0,         32'h0000_1000};
    vecs[1] = '{32'h0000_1000, 32'd7,         32'h0000_1000};
    vecs[2] = '{32'h0000_1000, 32'd8,         32'h0000_1010};
    vecs[3] = '{32'h0000_1000, 32'd15,        32'h0000_1010};
    vecs[4] = '{32'h0000_1000, 32'h100,       32'h0000_1200};
    vecs[5] = '{32'h0000_0000, 32'd9,         32'h0000_0010};
    vecs[6] = '{32'hFFFF_FFF0, 32'd8,         32'h0000_0000};
    vecs[7] = '{32'h0000_1000, 32'hFFFF_FFFF, 32'h0000_0FF0};
    vecs[8] = '{32'h2000_0003, 32'd17,        32'h2000_0023};

    reset    = 1'b1;
    confAddr = 32'h1000;
    tvalid   = 1'b0;
    tlast    = 1'b0;
    tdest    = '0;
    arready  = 1'b1;
    set_r(1'b1);
    tick();
    tick();

    // Reset state
    check("rst_arvalid", arvalid, 0);
    check("rst_arid", arid, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arlen", arlen, 3);
    check("rst_arsize", arsize, 2);
    check("rst_arburst", arburst, 1);
    check("rst_arlock", arlock, 0);
    check("rst_arcache", arcache, 0);
    check("rst_arprot", arprot, 0);
    check("rst_tready", tready, 1);
    addr_q.delete();
    id_q.delete();
    reset = 1'b0;

    // Address mapping table, one request per beat
    for (int i = 0; i < 9; i++) begin
      confAddr = vecs[i].conf;
      send(vecs[i].dest, 1'b1);
      settle(8);
      check("vec_count", addr_q.size(), i + 1);
      check_req("vec", i, vecs[i].addr, 8'(i));
    end

    // Whole line 0..7, tlast on 7
    do_reset();
    confAddr = 32'h1000;
    for (int i = 0; i < 8; i++) send(32'(i), i == 7);
    settle(30);
`ifdef MRGEN_TAG_FILTER_EN
    check("line_count", addr_q.size(), 1);
`else
    check("line_count", addr_q.size(), 8);
    check_req("line_last", 7, 32'h1000, 8'd7);
`endif
    check_req("line_first", 0, 32'h1000, 8'd0);
    check("line_arlen", arlen, 3);
    check("line_arsize", arsize, 2);

    // 7, 8, 8, 15 without tlast
    do_reset();
    send(32'd7, 1'b0);
    send(32'd8, 1'b0);
    send(32'd8, 1'b0);
    send(32'd15, 1'b0);
    settle(20);
    check_req("merge0", 0, 32'h1000, 8'd0);
    check_req("merge1", 1, 32'h1010, 8'd1);
`ifdef MRGEN_TAG_FILTER_EN
    check("merge_count", addr_q.size(), 2);
`else
    check("merge_count", addr_q.size(), 4);
    check_req("merge3", 3, 32'h1010, 8'd3);
`endif

    // tlast clears the filter: 3(tlast), 3, 3
    do_reset();
    send(32'd3, 1'b1);
    send(32'd3, 1'b0);
    send(32'd3, 1'b0);
    settle(20);
`ifdef MRGEN_TAG_FILTER_EN
    check("tlast_count", addr_q.size(), 2);
`else
    check("tlast_count", addr_q.size(), 3);
`endif
    check_req("tlast1", 1, 32'h1000, 8'd1);

    // Backpressure: one held in WAIT, FIFO fills to 4
    do_reset();
    arready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'(i * 8), 1'b1);
    @(negedge aclk);
    check("bp_tready", tready, 0);
    check("bp_arvalid", arvalid, 1);
    check("bp_araddr0", araddr, 32'h1000);
    settle(3);
    @(negedge aclk);
    check("bp_araddr1", araddr, 32'h1000);
    check("bp_count0", addr_q.size(), 0);
    tick();
    arready = 1'b1;
    settle(20);
    check("bp_count", addr_q.size(), 5);
    for (int i = 0; i < 5; i++) check_req("bp", i, 32'h1000 + 32'(i * 16), 8'(i));
    check("bp_tready_after", tready, 1);

    // Outstanding limit of 2
    do_reset();
    set_r(1'b0);
    for (int i = 0; i < 4; i++) send(32'(i * 8), 1'b1);
    settle(10);
    check("lim_count2", addr_q.size(), 2);
    pulse_r();
    settle(6);
    check("lim_count3", addr_q.size(), 3);
    pulse_r();
    settle(6);
    check("lim_count4", addr_q.size(), 4);
    check_req("lim3", 3, 32'h1030, 8'd3);

    // Reset mid-operation with arvalid high and 3 queued entries
    do_reset();
    send(32'd0, 1'b1);
    settle(5);
    arready = 1'b0;
    for (int i = 1; i < 5; i++) send(32'(i * 8), 1'b1);
    settle(2);
    @(negedge aclk);
    check("mid_arvalid", arvalid, 1);
    check("mid_arid", arid, 1);
    check("mid_araddr", araddr, 32'h1010);
    tick();
    reset = 1'b1;
    #2;
    check("mid_rst_arvalid", arvalid, 0);
    check("mid_rst_araddr", araddr, 0);
    check("mid_rst_arid", arid, 0);
    check("mid_rst_tready", tready, 1);
    tick();
    addr_q.delete();
    id_q.delete();
    reset   = 1'b0;
    arready = 1'b1;
    settle(10);
    check("mid_no_reqs", addr_q.size(), 0);
    pulse_r();
    settle(3);
    for (int i = 0; i < 3; i++) send(32'(i * 8), 1'b1);
    settle(12);
    check("mid_post_count", addr_q.size(), 2);
    check_req("mid_post0", 0, 32'h1000, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
